seq_pattern_tx: RTL and testbench

SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

---
 rtl/seq_pattern_tx_if.sv | 37 +++
 rtl/seq_pattern_tx.sv | 144 ++++++++++++++
 tb/tb_seq_pattern_tx.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_pattern_tx_if.sv
// Handshake and serial-output bundle for seq_pattern_tx.
//   master : request side (drives start_valid, pattern, rep_count, gap_len, abort)
//   slave  : transmitter side (drives start_ready, out, out_valid, busy, done)
// Signal meanings:
//   start_valid/start_ready : request handshake, accepted when both high at a clock edge
//   pattern                 : bit pattern to send, MSB first
//   rep_count               : extra repetitions (total transmissions = rep_count + 1)
//   gap_len                 : idle cycles inserted between repetitions (0..7)
//   abort                   : synchronous cancel of the transmission in progress
//   out/out_valid           : serial data bit and its qualifier
//   busy                    : transmitter not idle
//   done                    : one-cycle pulse after the final bit of the final repetition
interface seq_pattern_tx_if #(
    parameter int unsigned PAT_LEN = 5,
    parameter int unsigned CNT_W   = 4
);
    logic               start_valid;
    logic               start_ready;
    logic [PAT_LEN-1:0] pattern;
    logic [CNT_W-1:0]   rep_count;
    logic [2:0]         gap_len;
    logic               abort;
    logic               out;
    logic               out_valid;
    logic               busy;
    logic               done;

    modport master (
        output start_valid, pattern, rep_count, gap_len, abort,
        input  start_ready, out, out_valid, busy, done
    );

    modport slave (
        input  start_valid, pattern, rep_count, gap_len, abort,
        output start_ready, out, out_valid, busy, done
    );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter. Captures a PAT_LEN-bit pattern on request and
// shifts it out MSB first, rep_count+1 times, with gap_len idle cycles between
// repetitions, then pulses done for one cycle.
// Ports:
//   clk : single clock, rising edge
//   rst : asynchronous active-high reset
//   bus : seq_pattern_tx_if slave modport (handshake, configuration, serial output)
module seq_pattern_tx #(
    parameter int unsigned PAT_LEN = 5,
    parameter int unsigned CNT_W   = 4
) (
    input logic             clk,
    input logic             rst,
    seq_pattern_tx_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(PAT_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PAT_LEN-1:0] pat_q, pat_d;
    logic [IDX_W-1:0]   idx_q, idx_d;     // index of the bit currently on out
    logic [CNT_W-1:0]   rep_q, rep_d;     // repetitions still to send after this one
    logic [2:0]         gap_q, gap_d;     // captured gap length
    logic [2:0]         gcnt_q, gcnt_d;   // gap cycles left, including the current one
    logic               out_q, out_d;
    logic               vld_q, vld_d;
    logic               done_q, done_d;
    logic [IDX_W-1:0]   idx_m1;

    assign idx_m1 = idx_q - IDX_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            idx_q   <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
            gcnt_q  <= '0;
            out_q   <= 1'b0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            gcnt_q  <= gcnt_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
        end
    end

    // Outputs are registered: each branch sets out/out_valid/done to the
    // values belonging to the state being entered.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
        gap_d   = gap_q;
        gcnt_d  = gcnt_q;
        out_d   = 1'b0;
        vld_d   = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // abort has no effect here; a simultaneous request is accepted
                if (bus.start_valid) begin
                    state_d = SHIFT;
                    pat_d   = bus.pattern;
                    rep_d   = bus.rep_count;
                    gap_d   = bus.gap_len;
                    idx_d   = LAST_IDX;
                    out_d   = bus.pattern[LAST_IDX];
                    vld_d   = 1'b1;
                end
            end

            SHIFT: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (idx_q != '0) begin
                    idx_d = idx_m1;
                    out_d = pat_q[idx_m1];
                    vld_d = 1'b1;
                end else if (rep_q == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    // counting down remaining repetitions avoids any wrap at max rep_count
                    rep_d = rep_q - CNT_W'(1);
                    if (gap_q == '0) begin
                        idx_d = LAST_IDX;
                        out_d = pat_q[LAST_IDX];
                        vld_d = 1'b1;
                    end else begin
                        state_d = GAP;
                        gcnt_d  = gap_q;
                    end
                end
            end

            GAP: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (gcnt_q == 3'd1) begin
                    state_d = SHIFT;
                    idx_d   = LAST_IDX;
                    out_d   = pat_q[LAST_IDX];
                    vld_d   = 1'b1;
                end else begin
                    gcnt_d = gcnt_q - 3'd1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.out         = out_q;
    assign bus.out_valid   = vld_q;
    assign bus.done        = done_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.start_ready = (state_q == IDLE);

endmodule

// File: tb/tb_seq_pattern_tx.sv
module tb_seq_pattern_tx;

    localparam int unsigned PAT_LEN = 5;
    localparam int unsigned CNT_W   = 4;

    typedef struct packed {
        logic v;   // out_valid
        logic o;   // out
        logic d;   // done
        logic b;   // busy
    } cyc_t;

    logic clk = 1'b0;
    logic rst;

    seq_pattern_tx_if #(.PAT_LEN(PAT_LEN), .CNT_W(CNT_W)) bus ();

    seq_pattern_tx #(.PAT_LEN(PAT_LEN), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    cyc_t       sb[$];
    cyc_t       exp_c;
    int         n_cmp = 0;
    int         n_err = 0;
    int         hits  = 0;
    int         nwin  = 0;
    logic [4:0] win   = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected per-cycle outputs following an acceptance edge.
    task automatic push_trace(input logic [PAT_LEN-1:0] pat, input int rep, input int gap);
        for (int r = 0; r <= rep; r++) begin
            for (int i = PAT_LEN - 1; i >= 0; i--)
                sb.push_back('{1'b1, pat[i], 1'b0, 1'b1});
            if (r < rep)
                for (int g = 0; g < gap; g++)
                    sb.push_back('{1'b0, 1'b0, 1'b0, 1'b1});
        end
        sb.push_back('{1'b0, 1'b0, 1'b1, 1'b1});
        sb.push_back('{1'b0, 1'b0, 1'b0, 1'b0});
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bus.start_ready === 1'b1) return;
        end
        check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int k = 0; k < 3000; k++) begin
            if (sb.size() == 0) return;
            @(negedge clk);
        end
        check("drain_timeout", sb.size(), 32'd0);
        sb.delete();
    endtask

    task automatic drive_req(input logic [PAT_LEN-1:0] pat, input int rep, input int gap, input logic ab);
        bus.start_valid = 1'b1;
        bus.pattern     = pat;
        bus.rep_count   = CNT_W'(rep);
        bus.gap_len     = 3'(gap);
        bus.abort       = ab;
    endtask

    task automatic send(input logic [PAT_LEN-1:0] pat, input int rep, input int gap, input logic ab);
        wait_ready();
        drive_req(pat, rep, gap, ab);
        @(posedge clk);
        push_trace(pat, rep, gap);
        #1;
        bus.start_valid = 1'b0;
        bus.abort       = 1'b0;
        drain();
    endtask

    // Abort asserted during cycle n after acceptance; outputs idle from cycle n+1.
    task automatic send_abort(input logic [PAT_LEN-1:0] pat, input int rep, input int gap, input int n);
        wait_ready();
        drive_req(pat, rep, gap, 1'b0);
        @(posedge clk);
        push_trace(pat, rep, gap);
        while (sb.size() > n) void'(sb.pop_back());
        for (int k = 0; k < 3; k++) sb.push_back('{1'b0, 1'b0, 1'b0, 1'b0});
        #1;
        bus.start_valid = 1'b0;
        repeat (n) @(negedge clk);
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        drain();
        check("ready_after_abort", bus.start_ready, 32'd1);
    endtask

    // Scoreboard consumer and 11011 detector on the serial stream.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (sb.size() > 0) begin
                exp_c = sb.pop_front();
                check("out_valid", bus.out_valid, exp_c.v);
                check("out",       bus.out,       exp_c.o);
                check("done",      bus.done,      exp_c.d);
                check("busy",      bus.busy,      exp_c.b);
            end
            if (bus.out_valid === 1'b0)
                check("out_zero_when_invalid", bus.out, 32'd0);
            if (bus.out_valid === 1'b1) begin
                win  = {win[3:0], bus.out};
                nwin = nwin + 1;
                if (nwin >= 5 && win == 5'b11011) hits = hits + 1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.start_valid = 1'b0;
        bus.pattern     = '0;
        bus.rep_count   = '0;
        bus.gap_len     = '0;
        bus.abort       = 1'b0;
        rst             = 1'b1;
        #3;
        check("rst_out",         bus.out,         32'd0);
        check("rst_out_valid",   bus.out_valid,   32'd0);
        check("rst_busy",        bus.busy,        32'd0);
        check("rst_done",        bus.done,        32'd0);
        check("rst_start_ready", bus.start_ready, 32'd1);
        #14;
        rst = 1'b0;

        // single transmission, no repeat
        send(5'b11011, 0, 0, 1'b0);
        // three transmissions separated by 3 idle cycles
        send(5'b10110, 2, 3, 1'b0);
        // two back-to-back transmissions seen by the detector
        hits = 0;
        nwin = 0;
        send(5'b11011, 1, 0, 1'b0);
        check("detector_hits", hits, 32'd2);

        // abort in SHIFT (third bit), in GAP, and in DONE
        send_abort(5'b10110, 3, 2, 3);
        send_abort(5'b11011, 1, 4, 7);
        send_abort(5'b01001, 0, 0, 6);

        // abort together with start in IDLE: request accepted
        send(5'b10011, 0, 2, 1'b1);

        // asynchronous reset mid-SHIFT
        wait_ready();
        drive_req(5'b11011, 2, 1, 1'b0);
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out",         bus.out,         32'd0);
        check("midrst_out_valid",   bus.out_valid,   32'd0);
        check("midrst_busy",        bus.busy,        32'd0);
        check("midrst_done",        bus.done,        32'd0);
        check("midrst_start_ready", bus.start_ready, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(5'b01101, 1, 1, 1'b0);

        // start_valid held high, maximum rep_count: 80 contiguous bits then re-accept
        wait_ready();
        drive_req(5'b11100, 15, 0, 1'b0);
        @(posedge clk);
        push_trace(5'b11100, 15, 0);
        repeat (16 * PAT_LEN + 1) @(posedge clk);
        @(negedge clk);
        bus.pattern   = 5'b10001;
        bus.rep_count = '0;
        @(posedge clk);
        push_trace(5'b10001, 0, 0);
        #1;
        bus.start_valid = 1'b0;
        drain();

        // random configurations
        for (int t = 0; t < 6; t++) begin
            logic [PAT_LEN-1:0] p;
            p = PAT_LEN'($urandom);
            send(p, int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), 1'b0);
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
